// File: rtl/preg_free_list.sv
`default_nettype none
// ============================================================================
// Module      : preg_free_list
// Description : Physical-register free list for the rename stage. A circular
//               buffer of NUM_PREGS preg indices with head (pop), tail (push),
//               occupancy count and a per-preg in_list vector. Rename pops one
//               preg per cycle; commit pushes one reclaimed preg per cycle.
//               Frees of p0 are ignored; frees of a preg already in the list
//               (dup_err) or into a full list (ovf_err) are dropped and
//               flagged with sticky error bits.
// Ports       : i_clk, i_rst_n (async active-low)
//               i_alloc_req -> o_alloc_gnt, o_alloc_preg (same-cycle grant)
//               i_free_valid, i_free_preg (reclaim from commit)
//               o_free_count, o_empty, o_dup_err, o_ovf_err (registered)
// Option      : PREG_FREELIST_BYPASS_EN - when the list is empty, an
//               acceptable free in the same cycle is handed straight to an
//               allocation request without touching the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module preg_free_list #(
    parameter int NUM_PREGS = 128,
    parameter int PREG_W    = 7,
    parameter int NUM_AREGS = 32,
    parameter int CNT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alloc_req,
    output logic              o_alloc_gnt,
    output logic [PREG_W-1:0] o_alloc_preg,
    input  logic              i_free_valid,
    input  logic [PREG_W-1:0] i_free_preg,
    output logic [CNT_W-1:0]  o_free_count,
    output logic              o_empty,
    output logic              o_dup_err,
    output logic              o_ovf_err
);

    localparam int c_INIT_CNT = NUM_PREGS - NUM_AREGS;

    logic [PREG_W-1:0]    r_mem [NUM_PREGS];
    logic [PREG_W-1:0]    r_head;
    logic [PREG_W-1:0]    r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [NUM_PREGS-1:0] r_in_list;
    logic                 r_dup_err;
    logic                 r_ovf_err;

    logic w_empty;
    logic w_full;
    logic w_free_nz;
    logic w_free_dup;
    logic w_free_ovf;
    logic w_free_ok;
    logic w_bypass;
    logic w_gnt;
    logic w_pop;
    logic w_push;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(NUM_PREGS));

    // p0 is the permanent x0 mapping and is never reclaimed.
    assign w_free_nz  = i_free_valid && (i_free_preg != '0);
    // The duplicate check uses the pre-edge in_list, so freeing the preg
    // being granted this very cycle is flagged as a duplicate.
    assign w_free_dup = w_free_nz && r_in_list[i_free_preg];
    assign w_free_ovf = w_free_nz && !w_free_dup && w_full;
    assign w_free_ok  = w_free_nz && !w_free_dup && !w_full;

`ifdef PREG_FREELIST_BYPASS_EN
    assign w_bypass   = w_empty && w_free_ok && i_alloc_req;
`else
    assign w_bypass   = 1'b0;
`endif

    assign w_gnt  = i_rst_n && i_alloc_req && (!w_empty || w_bypass);
    // A bypassed preg goes straight to rename; the buffer is untouched.
    assign w_pop  = w_gnt && !w_bypass;
    assign w_push = w_free_ok && !w_bypass;

    assign o_alloc_gnt  = w_gnt;
    assign o_alloc_preg = w_bypass ? i_free_preg : r_mem[r_head];
    assign o_free_count = r_count;
    assign o_empty      = w_empty;
    assign o_dup_err    = r_dup_err;
    assign o_ovf_err    = r_ovf_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_mem[i]     <= (i < c_INIT_CNT) ? PREG_W'(i + NUM_AREGS) : '0;
                r_in_list[i] <= (i >= NUM_AREGS);
            end
            r_head    <= '0;
            r_tail    <= PREG_W'(c_INIT_CNT);
            r_count   <= CNT_W'(c_INIT_CNT);
            r_dup_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            // A popped preg and an accepted free can never be the same preg
            // (that case is a duplicate), so clear and set never collide.
            if (w_pop) begin
                r_head                    <= r_head + 1'b1;
                r_in_list[r_mem[r_head]]  <= 1'b0;
            end
            if (w_push) begin
                r_mem[r_tail]             <= i_free_preg;
                r_tail                    <= r_tail + 1'b1;
                r_in_list[i_free_preg]    <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_free_dup) r_dup_err <= 1'b1;
            if (w_free_ovf) r_ovf_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_preg_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_preg_free_list
// Description : Self-checking bench for preg_free_list. A queue holds the
//               expected free-list contents (the order grants must come out
//               in); frees push onto it, grants pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preg_free_list;

`ifdef PREG_FREELIST_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [6:0] alloc_preg;
    logic       free_valid;
    logic [6:0] free_preg;
    logic [7:0] free_count;
    logic       empty;
    logic       dup_err;
    logic       ovf_err;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard: expected grant order, plus model state.
    int q[$];
    bit m_inl [128];
    bit m_dup;
    bit m_ovf;
    int hist[$];

    preg_free_list dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_alloc_req (alloc_req),
        .o_alloc_gnt (alloc_gnt),
        .o_alloc_preg(alloc_preg),
        .i_free_valid(free_valid),
        .i_free_preg (free_preg),
        .o_free_count(free_count),
        .o_empty     (empty),
        .o_dup_err   (dup_err),
        .o_ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 32; i < 128; i++) q.push_back(i);
        for (int i = 0; i < 128; i++) m_inl[i] = (i >= 32);
        m_dup = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic check_regs();
        chk("free_count", int'(free_count), q.size());
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("dup_err", int'(dup_err), int'(m_dup));
        chk("ovf_err", int'(ovf_err), int'(m_ovf));
    endtask

    // Called at posedge+1: drives one cycle, checks combinational outputs
    // mid-cycle, advances the model, then checks registered outputs.
    task automatic step(input bit req, input bit fv, input int fp, output int gp);
        bit mempty, dup, ovf, ok, byp, egnt;
        int ep;
        alloc_req  = req;
        free_valid = fv;
        free_preg  = 7'(fp);
        #4;
        mempty = (q.size() == 0);
        dup    = fv && fp != 0 && m_inl[fp];
        ovf    = fv && fp != 0 && !dup && q.size() == 128;
        ok     = fv && fp != 0 && !dup && !ovf;
        byp    = c_BYP && mempty && ok && req;
        egnt   = req && (!mempty || byp);
        ep     = -1;
        chk("alloc_gnt", int'(alloc_gnt), int'(egnt));
        if (egnt) begin
            ep = byp ? fp : q[0];
            chk("alloc_preg", int'(alloc_preg), ep);
        end
        gp = ep;
        if (egnt && !byp) begin
            m_inl[q[0]] = 1'b0;
            void'(q.pop_front());
        end
        if (ok && !byp) begin
            q.push_back(fp);
            m_inl[fp] = 1'b1;
        end
        if (dup) m_dup = 1'b1;
        if (ovf) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_preg  = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        rst_n      = 1'b0;
        alloc_req  = 1'b1;   // request during reset must not be granted
        free_valid = 1'b0;
        free_preg  = '0;
        model_reset();
        #12;
        chk("rst_gnt", int'(alloc_gnt), 0);
        chk("rst_preg", int'(alloc_preg), 32);
        check_regs();
        alloc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Duplicate free of an in-list preg, then an ignored free of p0.
        step(0, 1, 50, g);
        chk("dup_sticky", int'(dup_err), 1);
        step(0, 1, 0, g);
        step(0, 0, 0, g);

        // Drain all 96 resets entries, then one more request on empty.
        for (int i = 0; i < 96; i++) begin
            step(1, 0, 0, g);
            chk("drain_order", g, 32 + i);
        end
        step(1, 0, 0, g);
        chk("empty_nogrant", g, -1);

        // FIFO order of reclaimed pregs.
        step(0, 1, 40, g);
        step(0, 1, 7, g);
        step(1, 0, 0, g);
        chk("fifo_first", g, 40);
        step(1, 0, 0, g);
        chk("fifo_second", g, 7);

        // Empty list, alloc and free of p45 in the same cycle.
        step(1, 1, 45, g);
        chk("same_cycle_grant", g, c_BYP ? 45 : -1);
        step(1, 0, 0, g);
        chk("after_bypass", g, c_BYP ? -1 : 45);

        // Steady-state recycling with pointer wrap past 127.
        for (int i = 100; i < 120; i++) step(0, 1, i, g);
        hist.delete();
        for (int k = 0; k < 40; k++) begin
            step(1, k >= 10, (k >= 10) ? hist[k - 10] : 0, g);
            hist.push_back(g);
        end
        alloc_req  = 1'b0;
        free_valid = 1'b0;

        // Asynchronous reset mid-stream with 50 entries in the list.
        reset_dut();
        for (int i = 0; i < 46; i++) step(1, 0, 0, g);
        chk("pre_rst_count", int'(free_count), 50);
        alloc_req = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", int'(alloc_gnt), 0);
        chk("async_preg", int'(alloc_preg), 32);
        check_regs();
        alloc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0, g);
        chk("post_rst_grant", g, 32);
        alloc_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
